// File: rtl/subt_pkg.sv
// Shared types and defaults for the subtractor operand loader.
package subt_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        CALC   = 2'b10,
        DONE   = 2'b11
    } loader_state_t;

    localparam int unsigned DEFAULT_N = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when the level goes from 0 to 1.
module rise_detect #(
    parameter logic PREV_RESET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Track the previous sample; resetting high blocks a press held across reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= PREV_RESET;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/subt_operand_loader.sv
// Captures A then B from a shared bus on load presses, drives the subtractor
// and registers its difference and carry-out for display.
module subt_operand_loader
    import subt_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         load_btn,
    input  logic         clear,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic         cin_out,
    input  logic [N-1:0] diff_in,
    input  logic         cout_in,
    output logic [N-1:0] result,
    output logic         result_cout,
    output logic         result_valid,
    output logic [1:0]   state_o
);

    loader_state_t state_q, state_d;
    logic [N-1:0]  a_d, b_d, result_d;
    logic          result_cout_d, result_valid_d;
    logic          load_rise;

    rise_detect #(
        .PREV_RESET(1'b1)
    ) u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .level(load_btn),
        .pulse(load_rise)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_A;
            a_out        <= '0;
            b_out        <= '0;
            result       <= '0;
            result_cout  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_out        <= a_d;
            b_out        <= b_d;
            result       <= result_d;
            result_cout  <= result_cout_d;
            result_valid <= result_valid_d;
        end
    end

    // Next-state and register updates; clear overrides any pending load.
    always_comb begin
        state_d        = state_q;
        a_d            = a_out;
        b_d            = b_out;
        result_d       = result;
        result_cout_d  = result_cout;
        result_valid_d = result_valid;
        if (clear) begin
            state_d        = WAIT_A;
            a_d            = '0;
            b_d            = '0;
            result_d       = '0;
            result_cout_d  = 1'b0;
            result_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_A: begin
                    if (load_rise) begin
                        a_d     = data_in;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_rise) begin
                        b_d     = data_in;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    // Presses landing here are dropped on purpose.
                    result_d       = diff_in;
                    result_cout_d  = cout_in;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
                DONE: begin
                    if (load_rise) begin
                        a_d            = data_in;
                        result_valid_d = 1'b0;
                        state_d        = WAIT_B;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    assign cin_out = 1'b1;
    assign state_o = state_q;

endmodule

// File: tb/tb_subt_operand_loader.sv
// Directed self-checking bench for subt_operand_loader with a behavioural
// magnitude subtractor connected behind it.
module tb_subt_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = '0;
    logic       load_btn = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] a_out, b_out, diff_in, result;
    logic       cin_out, cout_in, result_cout, result_valid;
    logic [1:0] state_o;

    int checks = 0;
    int failures = 0;

    subt_operand_loader #(
        .N(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_btn    (load_btn),
        .clear       (clear),
        .a_out       (a_out),
        .b_out       (b_out),
        .cin_out     (cin_out),
        .diff_in     (diff_in),
        .cout_in     (cout_in),
        .result      (result),
        .result_cout (result_cout),
        .result_valid(result_valid),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Subtractor model: |A-B| with carry-out following carry-in.
    always_comb begin
        diff_in = (a_out >= b_out) ? (a_out - b_out) : (b_out - a_out);
        cout_in = cin_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        data_in  = v;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        step();
    endtask

    task automatic do_reset();
        load_btn = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks += 7;
        if (a_out !== 4'd0) begin failures++; $display("FAIL reset_a got=%0d exp=0", a_out); end
        if (b_out !== 4'd0) begin failures++; $display("FAIL reset_b got=%0d exp=0", b_out); end
        if (result !== 4'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        if (result_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", result_cout); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        if (state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state_o); end
        if (cin_out !== 1'b1) begin failures++; $display("FAIL reset_cin got=%b exp=1", cin_out); end
        do_reset();
    endtask

    task automatic test_a_gt_b();
        press(4'd9);
        checks += 2;
        if (a_out !== 4'd9) begin failures++; $display("FAIL gt_a got=%0d exp=9", a_out); end
        if (state_o !== 2'b01) begin failures++; $display("FAIL gt_state_b got=%b exp=01", state_o); end
        data_in  = 4'd3;
        load_btn = 1'b1;
        step();
        load_btn = 1'b0;
        checks += 3;
        if (b_out !== 4'd3) begin failures++; $display("FAIL gt_b got=%0d exp=3", b_out); end
        if (state_o !== 2'b10) begin failures++; $display("FAIL gt_calc got=%b exp=10", state_o); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL gt_valid_early got=%b exp=0", result_valid); end
        step();
        checks += 4;
        if (result !== 4'd6) begin failures++; $display("FAIL gt_result got=%0d exp=6", result); end
        if (result_cout !== 1'b1) begin failures++; $display("FAIL gt_cout got=%b exp=1", result_cout); end
        if (result_valid !== 1'b1) begin failures++; $display("FAIL gt_valid got=%b exp=1", result_valid); end
        if (state_o !== 2'b11) begin failures++; $display("FAIL gt_done got=%b exp=11", state_o); end
        // Idle in DONE with changing bus: nothing moves.
        data_in = 4'd15;
        repeat (3) step();
        checks += 2;
        if (state_o !== 2'b11) begin failures++; $display("FAIL gt_hold_state got=%b exp=11", state_o); end
        if (a_out !== 4'd9) begin failures++; $display("FAIL gt_hold_a got=%0d exp=9", a_out); end
    endtask

    task automatic test_new_from_done();
        press(4'd12);
        checks += 4;
        if (a_out !== 4'd12) begin failures++; $display("FAIL done_a got=%0d exp=12", a_out); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL done_valid got=%b exp=0", result_valid); end
        if (result !== 4'd6) begin failures++; $display("FAIL done_keep got=%0d exp=6", result); end
        if (state_o !== 2'b01) begin failures++; $display("FAIL done_state got=%b exp=01", state_o); end
        press(4'd4);
        step();
        checks += 2;
        if (result !== 4'd8) begin failures++; $display("FAIL done_result got=%0d exp=8", result); end
        if (result_valid !== 1'b1) begin failures++; $display("FAIL done_valid2 got=%b exp=1", result_valid); end
    endtask

    task automatic test_a_lt_b_and_equal();
        do_reset();
        press(4'd3);
        press(4'd9);
        step();
        checks += 3;
        if (result !== 4'd6) begin failures++; $display("FAIL lt_result got=%0d exp=6", result); end
        if (result_cout !== 1'b1) begin failures++; $display("FAIL lt_cout got=%b exp=1", result_cout); end
        if (b_out !== 4'd9) begin failures++; $display("FAIL lt_b got=%0d exp=9", b_out); end
        press(4'd5);
        press(4'd5);
        step();
        checks += 3;
        if (result !== 4'd0) begin failures++; $display("FAIL eq_result got=%0d exp=0", result); end
        if (result_cout !== 1'b1) begin failures++; $display("FAIL eq_cout got=%b exp=1", result_cout); end
        if (result_valid !== 1'b1) begin failures++; $display("FAIL eq_valid got=%b exp=1", result_valid); end
    endtask

    task automatic test_held_button();
        do_reset();
        data_in  = 4'd7;
        load_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) data_in = 4'd2;
        end
        load_btn = 1'b0;
        step();
        checks += 3;
        if (a_out !== 4'd7) begin failures++; $display("FAIL held_a got=%0d exp=7", a_out); end
        if (b_out !== 4'd0) begin failures++; $display("FAIL held_b got=%0d exp=0", b_out); end
        if (state_o !== 2'b01) begin failures++; $display("FAIL held_state got=%b exp=01", state_o); end
    endtask

    task automatic test_clear();
        do_reset();
        press(4'd9);
        press(4'd3);
        step();
        press(4'd1);
        // WAIT_B with a=1, b=3; clear together with a fresh rising edge.
        data_in  = 4'd10;
        load_btn = 1'b1;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        step();
        load_btn = 1'b0;
        step();
        checks += 4;
        if (a_out !== 4'd0) begin failures++; $display("FAIL clr_a got=%0d exp=0", a_out); end
        if (b_out !== 4'd0) begin failures++; $display("FAIL clr_b got=%0d exp=0", b_out); end
        if (state_o !== 2'b00) begin failures++; $display("FAIL clr_state got=%b exp=00", state_o); end
        if (result !== 4'd0) begin failures++; $display("FAIL clr_result got=%0d exp=0", result); end
        press(4'd6);
        press(4'd2);
        step();
        checks += 1;
        if (result !== 4'd4) begin failures++; $display("FAIL clr_pre got=%0d exp=4", result); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks += 4;
        if (result !== 4'd0) begin failures++; $display("FAIL clr_done_result got=%0d exp=0", result); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL clr_done_valid got=%b exp=0", result_valid); end
        if (result_cout !== 1'b0) begin failures++; $display("FAIL clr_done_cout got=%b exp=0", result_cout); end
        if (state_o !== 2'b00) begin failures++; $display("FAIL clr_done_state got=%b exp=00", state_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(4'd9);
        data_in  = 4'd3;
        load_btn = 1'b1;
        step();
        checks += 1;
        if (state_o !== 2'b10) begin failures++; $display("FAIL ar_calc got=%b exp=10", state_o); end
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (a_out !== 4'd0) begin failures++; $display("FAIL ar_a got=%0d exp=0", a_out); end
        if (b_out !== 4'd0) begin failures++; $display("FAIL ar_b got=%0d exp=0", b_out); end
        if (result !== 4'd0) begin failures++; $display("FAIL ar_result got=%0d exp=0", result); end
        if (result_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", result_valid); end
        if (state_o !== 2'b00) begin failures++; $display("FAIL ar_state got=%b exp=00", state_o); end
        if (cin_out !== 1'b1) begin failures++; $display("FAIL ar_cin got=%b exp=1", cin_out); end
        step();
        data_in = 4'd11;
        rst     = 1'b0;
        repeat (3) step();
        checks += 2;
        if (state_o !== 2'b00) begin failures++; $display("FAIL ar_held_state got=%b exp=00", state_o); end
        if (a_out !== 4'd0) begin failures++; $display("FAIL ar_held_a got=%0d exp=0", a_out); end
        load_btn = 1'b0;
        step();
        press(4'd5);
        checks += 2;
        if (a_out !== 4'd5) begin failures++; $display("FAIL ar_repress_a got=%0d exp=5", a_out); end
        if (state_o !== 2'b01) begin failures++; $display("FAIL ar_repress_state got=%b exp=01", state_o); end
    endtask

    initial begin
        test_reset();
        test_a_gt_b();
        test_new_from_done();
        test_a_lt_b_and_equal();
        test_held_button();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
